serial_tx_feeder: RTL and testbench
===================================

# serial_tx_feeder

Parallel-to-serial feeder that sits directly upstream of the 4-bit serial-in shift register. It accepts parallel words over a valid/ready handshake and drives that register's `serial_in` and `shift_enable` pins, one bit per clock. Bits go MSB-first, so after WIDTH shifts the downstream `q` equals the accepted word. A one-word holding buffer lets consecutive words stream with no idle cycles, and a `pause` input stalls the bit stream without losing data.

## Interface
- `WIDTH`, default 4: bits per word; legal range 2..16; must match the downstream register width.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clk`  input  1  single clock; all logic is rising-edge.
- `reset_n`  input  1  asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `in_valid`  input  1  `in_data` holds a word to transfer.
- `in_data`  input  WIDTH  parallel word.
- `in_ready`  output  1  holding buffer is empty; a transfer occurs on a rising edge with `in_valid & in_ready`.
- `pause`  input  1  freezes the serial stream.
- `serial_out`  output  1  current bit; connects to downstream `serial_in`.
- `shift_enable`  output  1  `serial_out` is valid this cycle; downstream shifts on the next edge.
- `word_done`  output  1  one-cycle pulse coincident with the last bit of each word.
- `busy`  output  1  shifter active or holding buffer full.

## Operation
- Storage:
  - `hold_data`/`hold_full` is a one-word buffer.
  - `shreg` is a WIDTH-bit shifter.
  - `bit_cnt` is a down-counter of width clog2(WIDTH+1).
- FSM states:
  - IDLE: shifter empty. If `hold_full`, go to SHIFT: load `shreg` from `hold_data`, clear `hold_full`, set `bit_cnt`=WIDTH.
  - SHIFT:
    - When `pause`=0, each edge advances `shreg` by one bit and decrements `bit_cnt`.
    - When `bit_cnt`==1 and `pause`=0, the edge reloads from hold if `hold_full` (stay in SHIFT, `bit_cnt`=WIDTH); otherwise go to IDLE.
- `in_ready` = !`hold_full` (registered state, no combinational path from `in_valid`).
- A push is allowed on the same edge the shifter drains the hold. The new word enters hold in that edge because `in_ready` reflected the pre-edge state.
- `serial_out` = `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`. It is 0 in IDLE.
- `shift_enable` = (state==SHIFT) & !`pause`.
- `word_done` = `shift_enable` & (`bit_cnt`==1).
- `busy` = (state==SHIFT) | `hold_full`.
- `pause` gates only the shifter and counter. Loading hold from the input and the IDLE→SHIFT transfer still occur during pause.
- Reset (async, `reset_n`=0):
  - State IDLE; `hold_full`=0; `shreg`=0; `bit_cnt`=0.
  - Outputs: `in_ready`=1, `serial_out`=0, `shift_enable`=0, `word_done`=0, `busy`=0.
  - A word partially shifted when reset asserts is discarded; no `word_done` is issued for it.

## Timing
- Word accepted at edge k (empty system):
  - `hold_full`=1 after k.
  - At edge k+1 the word loads into `shreg`.
  - `shift_enable`=1 during cycles k+1..k+WIDTH (cycle n = between edges n and n+1).
  - Downstream samples at edges k+2..k+WIDTH+1.
- `word_done` is high in cycle k+WIDTH.
- Back-to-back streaming:
  - With hold refilled in time, `shift_enable` stays continuously high across word boundaries: sustained 1 word per WIDTH cycles.
  - `in_ready` is high at most 1 cycle in every WIDTH while streaming.
- Pause asserted in cycle c: `shift_enable`=0 and `serial_out` is held for that cycle. Shifting resumes in the first cycle with `pause`=0.
- Pause on the last bit: `word_done` is suppressed until the bit is actually shifted.

## Test plan
- **Reset:** `reset_n`=0 mid-word, then release → all outputs at reset values; next push of 4'hA produces a fresh 4-bit stream 1,0,1,0 with no remnants.
- **Single word, WIDTH=4:** push 4'b1011 at edge 0 → `shift_enable` high for cycles 1–4, `serial_out` 1,0,1,1; `word_done` in cycle 4; downstream `q`=4'b1011 after edge 5; `busy` low from cycle 5.
- **Back-to-back:** push 4'h3, 4'hC, 4'h5 with `in_valid` held → 12 consecutive `shift_enable` cycles; `word_done` every 4th; downstream `q` reads 3, C, 5 at successive word boundaries.
- **Backpressure:** hold `in_valid`=1 with changing data while `in_ready`=0 → no word lost or duplicated; exactly one acceptance per WIDTH cycles.
- **Pause:** assert `pause` for 3 cycles during bit 2 of 4'h9 → stream gap of 3 cycles; bits still 1,0,0,1; `word_done` delayed 3 cycles; a word pushed during pause is not lost.
- **LSB-first, MSB_FIRST=0, WIDTH=8:** push 8'h81 → `serial_out` 1,0,0,0,0,0,0,1; `word_done` on the 8th bit.

Source files
------------

// File: rtl/serial_tx_feeder.sv
// serial_tx_feeder: parallel-to-serial feeder with a one-word holding buffer.
// Drives serial_in/shift_enable of a downstream serial-in shift register.
module serial_tx_feeder #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  input  logic             pause_i,
  output logic             serial_out_o,
  output logic             shift_enable_o,
  output logic             word_done_o,
  output logic             busy_o
);
  // state | meaning
  // IDLE  | shifter empty; moves to SHIFT as soon as hold is full
  // SHIFT | shreg holds a word; one bit leaves per unpaused cycle
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             advance, last_bit, load, push;

  assign advance  = (state_q == SHIFT) && !pause_i;
  assign last_bit = advance && (bit_cnt_q == CNT_ONE);
  // hold drains on the IDLE->SHIFT transfer (even while paused) or on the last bit
  assign load     = hold_full_q && ((state_q == IDLE) || last_bit);
  assign push     = in_valid_i && !hold_full_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_full_q) state_d = SHIFT;
      SHIFT:   if (last_bit && !hold_full_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    if (load) begin
      shreg_d     = hold_data_q;
      bit_cnt_d   = CNT_FULL;
      hold_full_d = 1'b0;
    end else if (advance) begin
      shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      bit_cnt_d = bit_cnt_q - CNT_ONE;
    end
    // push and load are exclusive: push needs hold empty, load needs it full
    if (push) begin
      hold_data_d = in_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    serial_out_o = 1'b0;
    if (state_q == SHIFT) serial_out_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    shift_enable_o = advance;
    word_done_o    = last_bit;
    busy_o         = (state_q == SHIFT) || hold_full_q;
    in_ready_o     = !hold_full_q;
  end

endmodule

// File: tb/tb_serial_tx_feeder.sv
// Bench for serial_tx_feeder: vector table, directed corner cases and a
// randomized run against a queue-based reference model with a downstream register.
module tb_serial_tx_feeder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       pause = 1'b0;
  logic       in_ready, serial_out, shift_enable, word_done, busy;
  logic       v8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       p8 = 1'b0;
  logic       r8, so8, se8, wd8, b8;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_tx_feeder #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .pause_i(pause), .serial_out_o(serial_out),
    .shift_enable_o(shift_enable), .word_done_o(word_done), .busy_o(busy));

  serial_tx_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(v8), .in_data_i(d8),
    .in_ready_o(r8), .pause_i(p8), .serial_out_o(so8),
    .shift_enable_o(se8), .word_done_o(wd8), .busy_o(b8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits still to send of the current word, the held word,
  // and every accepted word that has not yet completed.
  bit         m_cur[$];
  logic [3:0] m_hold[$];
  logic [3:0] m_acc[$];
  logic [3:0] q_ds = 4'h0;
  logic [3:0] q_exp = 4'h0;
  bit         q_chk = 1'b0;

  always @(negedge reset_n) begin
    m_cur.delete();
    m_hold.delete();
    m_acc.delete();
    q_chk = 1'b0;
  end

  always @(posedge clk) begin
    bit         do_push;
    logic [3:0] w;
    if (reset_n) begin
      if (shift_enable) q_ds = {q_ds[2:0], serial_out};
      if (m_cur.size() == 1 && !pause) begin
        q_chk = 1'b1;
        q_exp = (m_acc.size() != 0) ? m_acc.pop_front() : 4'hx;
      end
      do_push = in_valid && (m_hold.size() == 0);
      if (m_cur.size() == 0) begin
        if (m_hold.size() != 0) begin
          w = m_hold.pop_front();
          for (int i = 3; i >= 0; i--) m_cur.push_back(w[i]);
        end
      end else if (!pause) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0 && m_hold.size() != 0) begin
          w = m_hold.pop_front();
          for (int i = 3; i >= 0; i--) m_cur.push_back(w[i]);
        end
      end
      if (do_push) begin
        m_hold.push_back(in_data);
        m_acc.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    bit active;
    active = (m_cur.size() != 0);
    chk("m_ready", in_ready, m_hold.size() == 0);
    chk("m_serial", serial_out, active ? m_cur[0] : 1'b0);
    chk("m_shift_en", shift_enable, active && !pause);
    chk("m_word_done", word_done, active && !pause && m_cur.size() == 1);
    chk("m_busy", busy, active || (m_hold.size() != 0));
    if (q_chk) begin
      chk("downstream_q", q_ds, q_exp);
      q_chk = 1'b0;
    end
  end

  typedef struct {
    logic v; logic [3:0] d; logic p;
    logic rdy; logic so; logic se; logic wd; logic bsy;
  } vec_t;
  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", busy, 1'b0);
  endtask

  initial begin
    logic [3:0] words[3];
    logic [7:0] bits;
    int nb, max_run, cur_run, wdc, wd_at, se_first, nacc;
    int acc_cyc[$];

    tbl[0] = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready8", r8, 1'b1);
    chk("rst_busy8", b8, 1'b0);
    chk("rst_se8", se8, 1'b0);
    step();

    // single word 1011 from the table
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; pause = tbl[i].p;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_serial", i), serial_out, tbl[i].so);
      chk($sformatf("tbl%0d_shift_en", i), shift_enable, tbl[i].se);
      chk($sformatf("tbl%0d_word_done", i), word_done, tbl[i].wd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      step();
    end
    in_valid = 1'b0;
    wait_idle();

    // back-to-back 3, C, 5 with in_valid held
    words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h5;
    nacc = 0; max_run = 0; cur_run = 0; wdc = 0;
    in_valid = 1'b1; in_data = words[0];
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) nacc++;
      if (shift_enable) cur_run++; else cur_run = 0;
      if (cur_run > max_run) max_run = cur_run;
      if (word_done) wdc++;
      step();
      if (nacc < 3) in_data = words[nacc]; else in_valid = 1'b0;
    end
    chk("b2b_accepts", nacc, 3);
    chk("b2b_se_run", max_run, 12);
    chk("b2b_word_done", wdc, 3);
    wait_idle();

    // backpressure: valid held, data changing every cycle
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_data = 4'($urandom);
      @(negedge clk);
      if (in_ready) acc_cyc.push_back(c);
      step();
    end
    in_valid = 1'b0;
    for (int k = 2; k < acc_cyc.size(); k++)
      chk($sformatf("bp_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 4);
    chk("bp_count", acc_cyc.size() >= 9, 1'b1);
    wait_idle();

    // pause for 3 cycles during bit 2 of 4'h9; push 4'h6 during the pause
    bits = 8'h00; nb = 0; wdc = 0; wd_at = -1; se_first = -1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c == 0) || (c == 4);
      in_data  = (c == 0) ? 4'h9 : 4'h6;
      pause    = (c >= 3) && (c <= 5);
      @(negedge clk);
      if (shift_enable) begin
        if (se_first < 0) se_first = c;
        if (nb < 4) begin bits = {bits[6:0], serial_out}; nb++; end
      end
      if (word_done) begin
        wdc++;
        if (wd_at < 0) wd_at = c;
      end
      step();
    end
    in_valid = 1'b0; pause = 1'b0;
    chk("pause_bits", bits[3:0], 4'h9);
    chk("pause_wd_delay", wd_at - se_first, 6);
    chk("pause_words", wdc, 2);
    wait_idle();

    // reset in the middle of a word, then a fresh 4'hA
    in_valid = 1'b1; in_data = 4'h5;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", in_ready, 1'b1);
    chk("rst_mid_serial", serial_out, 1'b0);
    chk("rst_mid_se", shift_enable, 1'b0);
    chk("rst_mid_wd", word_done, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    bits = 8'h00; nb = 0; wdc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0); in_data = 4'hA;
      @(negedge clk);
      if (shift_enable) begin bits = {bits[6:0], serial_out}; nb++; end
      if (word_done) wdc++;
      step();
    end
    in_valid = 1'b0;
    chk("rst_fresh_bits", bits[3:0], 4'hA);
    chk("rst_fresh_nbits", nb, 4);
    chk("rst_fresh_wd", wdc, 1);

    // LSB-first WIDTH=8: 8'h81 then 8'h03
    for (int t = 0; t < 2; t++) begin
      bits = 8'h00; nb = 0; wd_at = -1;
      for (int c = 0; c < 14; c++) begin
        v8 = (c == 0); d8 = (t == 0) ? 8'h81 : 8'h03;
        @(negedge clk);
        if (se8) begin bits = {bits[6:0], so8}; nb++; end
        if (wd8 && wd_at < 0) wd_at = nb;
        step();
      end
      v8 = 1'b0;
      chk($sformatf("lsb%0d_bits", t), bits, (t == 0) ? 8'h81 : 8'hC0);
      chk($sformatf("lsb%0d_nbits", t), nb, 8);
      chk($sformatf("lsb%0d_wd_bit", t), wd_at, 8);
    end

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      in_data  = 4'($urandom);
      pause    = ($urandom_range(0, 99) < 15);
      step();
    end
    in_valid = 1'b0; pause = 1'b0;
    wait_idle();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
